// File: rtl/sar_search_3bit.sv
// Successive-approximation search controller.
// Drives a trial value onto an external comparator, resolves one bit per
// PROBE cycle from the comparator flags, and reports the converged value.
// Optional feature: define SAR_EQ_EARLY_EXIT_EN to finish as soon as the
// comparator reports a clean equality, instead of always running WIDTH probes.
module sar_search_3bit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             A_eq_B,
  input  logic             A_lt_B,
  input  logic             A_gt_B,
  output logic [WIDTH-1:0] guess,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int                IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [WIDTH-1:0]  MSB_ONLY = WIDTH'(1) << (WIDTH - 1);

`ifdef SAR_EQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] guess_nxt, result_nxt;
  logic             err_nxt;
  logic [2:0]       flags;
  logic             flags_onehot;

  // A flag set is trusted only when exactly one comparator output is high.
  assign flags        = {A_lt_B, A_eq_B, A_gt_B};
  assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

  // Status outputs are pure decodes of the registered state.
  assign busy = (state == PROBE);
  assign done = (state == DONE);

  // Next-state and datapath updates for the search sequence.
  always_comb begin
    // NOTE: every signal written here gets a hold default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    state_nxt  = state;
    idx_nxt    = idx;
    guess_nxt  = guess;
    result_nxt = result;
    err_nxt    = err;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PROBE;
          guess_nxt = MSB_ONLY;
          idx_nxt   = IDX_TOP;
          err_nxt   = 1'b0;
        end
      end

      PROBE: begin
        if (!flags_onehot) begin
          err_nxt = 1'b1;
        end

        if (EARLY_EXIT && flags_onehot && A_eq_B) begin
          result_nxt = guess;
          state_nxt  = DONE;
        end else begin
          // Target below the trial value: this bit overshoots, drop it.
          // Anything else, including a corrupt flag set, keeps the bit.
          if (flags_onehot && A_lt_B) begin
            guess_nxt[idx] = 1'b0;
          end
          if (idx != '0) begin
            guess_nxt[idx - IDX_ONE] = 1'b1;
            idx_nxt                  = idx - IDX_ONE;
          end else begin
            result_nxt = guess_nxt;
            state_nxt  = DONE;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= IDX_TOP;
      guess  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      guess  <= guess_nxt;
      result <= result_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sar_search_3bit.sv
// Self-checking bench for sar_search_3bit.
// A behavioural comparator answers the DUT's guesses for a chosen target;
// a binary-search reference model predicts every guess, result and flag.
// Build with SAR_EQ_EARLY_EXIT_EN defined to check the early-exit variant.
module tb_sar_search_3bit;

  localparam int WIDTH = 3;

`ifdef SAR_EQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             a_eq_b, a_lt_b, a_gt_b;
  logic [WIDTH-1:0] guess, result;
  logic             busy, done, err;

  int   target;
  logic force_bad;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model predictions for the current search.
  int exp_g [WIDTH];
  int exp_n;
  int exp_res;

  sar_search_3bit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A_eq_B (a_eq_b),
    .A_lt_B (a_lt_b),
    .A_gt_B (a_gt_b),
    .guess  (guess),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Comparator: target is operand A, the DUT guess is operand B.
  // force_bad produces the illegal set lt=gt=1, eq=0.
  assign a_lt_b = force_bad | (target < int'(guess));
  assign a_gt_b = force_bad | (target > int'(guess));
  assign a_eq_b = !force_bad & (target == int'(guess));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Binary search on the target: probe prefix+bit, keep the bit when the
  // target is not below it (or when the flags were corrupted on that probe).
  task automatic model(input int t, input int force_step);
    int prefix;
    int g;
    bit forced;
    prefix  = 0;
    exp_n   = WIDTH;
    exp_res = -1;
    for (int k = 0; k < WIDTH; k++) begin
      g        = prefix + (1 << (WIDTH - 1 - k));
      exp_g[k] = g;
      forced   = (k == force_step);
      if (EARLY_EXIT && !forced && t == g) begin
        exp_n   = k + 1;
        exp_res = g;
        break;
      end
      if (forced || t >= g) prefix = g;
    end
    if (exp_res < 0) exp_res = prefix;
  endtask

  // One full search from a single-cycle start pulse, checked every cycle.
  task automatic run_search(input int t, input int force_step);
    bit err_exp;
    model(t, force_step);
    target = t;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < exp_n; k++) begin
      err_exp = (force_step >= 0) && (force_step < k);
      check($sformatf("probe_guess t=%0d k=%0d", t, k), 32'(guess), 32'(exp_g[k]));
      check($sformatf("probe_busy t=%0d k=%0d", t, k), 32'(busy), 32'd1);
      check($sformatf("probe_done t=%0d k=%0d", t, k), 32'(done), 32'd0);
      check($sformatf("probe_err t=%0d k=%0d", t, k), 32'(err), 32'(err_exp));
      force_bad = (k == force_step);
      @(negedge clk);
      force_bad = 1'b0;
    end
    err_exp = (force_step >= 0) && (force_step < exp_n);
    check($sformatf("done_pulse t=%0d", t), 32'(done), 32'd1);
    check($sformatf("done_busy t=%0d", t), 32'(busy), 32'd0);
    check($sformatf("done_result t=%0d", t), 32'(result), 32'(exp_res));
    check($sformatf("done_guess t=%0d", t), 32'(guess), 32'(exp_res));
    check($sformatf("done_err t=%0d", t), 32'(err), 32'(err_exp));
    @(negedge clk);
    check($sformatf("idle_done t=%0d", t), 32'(done), 32'd0);
    check($sformatf("idle_busy t=%0d", t), 32'(busy), 32'd0);
    check($sformatf("idle_result t=%0d", t), 32'(result), 32'(exp_res));
    check($sformatf("idle_err t=%0d", t), 32'(err), 32'(err_exp));
  endtask

  initial begin
    int t;
    int f;
    int phase;

    rst_n     = 1'b0;
    start     = 1'b0;
    target    = 0;
    force_bad = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_guess", 32'(guess), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Directed targets: mid value, both ends, MSB-only value.
    run_search(5, -1);
    run_search(0, -1);
    run_search(7, -1);
    run_search(4, -1);

    // Corrupt flag set on the first probe; the following search clears err.
    run_search(2, 0);
    run_search(6, -1);
    run_search(1, 2);

    // Random targets, some with a corrupted probe.
    for (int i = 0; i < 10; i++) begin
      t = int'($urandom_range(0, (1 << WIDTH) - 1));
      f = int'($urandom_range(0, WIDTH));
      if (f == WIDTH) f = -1;
      run_search(t, f);
    end

    // start held high for 10 cycles: no queuing, a new search only from IDLE.
    model(3, -1);
    target = 3;
    start  = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      phase = c % (WIDTH + 2);
      check($sformatf("hold_busy c=%0d", c), 32'(busy), 32'((phase >= 1) && (phase <= WIDTH)));
      check($sformatf("hold_done c=%0d", c), 32'(done), 32'(phase == WIDTH + 1));
      if (phase >= 1 && phase <= WIDTH)
        check($sformatf("hold_guess c=%0d", c), 32'(guess), 32'(exp_g[phase-1]));
      if (phase == WIDTH + 1)
        check($sformatf("hold_result c=%0d", c), 32'(result), 32'(exp_res));
    end
    @(negedge clk);
    start = 1'b0;
    check("hold_end_busy", 32'(busy), 32'd0);
    check("hold_end_done", 32'(done), 32'd0);
    @(negedge clk);
    check("hold_after_busy", 32'(busy), 32'd0);

    // Reset on the second probe cycle of a search that already flagged err.
    target = 6;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    force_bad = 1'b1;
    @(negedge clk);
    force_bad = 1'b0;
    check("pre_rst_err", 32'(err), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_guess", 32'(guess), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    // Reset wins over start.
    start = 1'b1;
    @(negedge clk);
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_nodone c=%0d", c), 32'(done), 32'd0);
      check($sformatf("post_rst_idle c=%0d", c), 32'(busy), 32'd0);
    end

    // Normal operation after the abandoned search.
    run_search(3, -1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/sar_search_3bit.md
SAR_SEARCH_3BIT -- requirements
Module: sar_search_3bit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 3, bit width of the search value and of the comparator operands.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request a new search; sampled only in IDLE.
REQ-005 The block SHALL have port A_eq_B, input, 1, comparator flag: target == guess.
REQ-006 The block SHALL have port A_lt_B, input, 1, comparator flag: target < guess.
REQ-007 The block SHALL have port A_gt_B, input, 1, comparator flag: target > guess.
REQ-008 The block SHALL have port guess, output, WIDTH, registered value driven onto the comparator B operand.
REQ-009 The block SHALL have port result, output, WIDTH, registered search result, valid when done is high.
REQ-010 The block SHALL have port busy, output, 1, high in PROBE.
REQ-011 The block SHALL have port done, output, 1, single-cycle pulse on search completion.
REQ-012 The block SHALL have port err, output, 1, sticky flag for a non-one-hot comparator flag set seen during PROBE.

Function
REQ-013 The block SHALL implement states IDLE, PROBE, DONE with transitions IDLE->PROBE on start, PROBE->DONE after the last bit resolves, DONE->IDLE unconditionally.
REQ-014 On IDLE with start=1, the next cycle SHALL have guess = MSB-only (3'b100 for WIDTH=3), bit index = WIDTH-1, busy=1, err=0.
REQ-015 Each PROBE cycle SHALL sample the flags against the current guess: if A_lt_B, clear bit[index]; otherwise keep it; if index>0, set bit[index-1] and decrement index.
REQ-016 A non-one-hot flag set {A_lt_B, A_eq_B, A_gt_B} in PROBE SHALL set err and SHALL be resolved as keep-bit.
REQ-017 When index==0 resolves, the block SHALL load result with the final guess and enter DONE; PROBE SHALL last exactly WIDTH cycles (absent early exit).
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and result and guess SHALL hold.
REQ-019 result SHALL hold its value until the next search completes; err SHALL hold until the next accepted start.
REQ-020 start asserted in PROBE or DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 Latency from start sampled high to done high SHALL be WIDTH+1 cycles.

Reset
REQ-022 When rst_n=0 at a rising clk edge, the block SHALL enter IDLE with guess=0, result=0, busy=0, done=0, err=0, index=WIDTH-1.
REQ-023 Reset during PROBE SHALL abandon the search with no done pulse; reset has priority over start.

Configuration
REQ-024 Macro SAR_EQ_EARLY_EXIT_EN defined: A_eq_B=1 (one-hot) in PROBE SHALL load result=guess and enter DONE immediately, regardless of index.
REQ-025 Macro SAR_EQ_EARLY_EXIT_EN undefined: A_eq_B SHALL be treated as keep-bit and PROBE SHALL always last WIDTH cycles.

Verification
REQ-026 WIDTH=3, target 5 via comparator model, start pulse -> guess 4,6,5 over 3 cycles; done at cycle 4; result=5; err=0.
REQ-027 Target 0 -> guess 4,2,1; result=0; target 7 -> guess 4,6,7; result=7.
REQ-028 SAR_EQ_EARLY_EXIT_EN defined, target 4 -> done 2 cycles after start, result=4; undefined -> done at cycle 4, result=4.
REQ-029 start held high for 10 cycles, target 3 -> exactly one search, result=3, second search starts only in IDLE on the cycle after DONE.
REQ-030 rst_n low on 2nd PROBE cycle -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-031 Force A_lt_B=A_gt_B=1 on one probe -> err=1 through done, cleared on next accepted start.
